issue_scoreboard: RTL and testbench

- Tracks in-flight destination registers between issue and register-file writeback.
- Generates the issue stall that holds the register-file stage while a source operand is not yet forwardable.
- Serialises dividers: only one divide may be in flight.
- Sits beside `register_file`. It sees the issue-stage pair (eu0/eu1) and the two exe2 writeback ports, and drives `stall_by_conflict` back to issue.

---
 rtl/issue_scoreboard_pkg.sv | 13 +
 rtl/issue_scoreboard_sb_entry.sv | 45 ++++
 rtl/issue_scoreboard.sv | 88 ++++++++
 tb/tb_issue_scoreboard.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared latency constants and helpers for the issue scoreboard
package issue_scoreboard_pkg;
    localparam int LAT_MUL = 2;
    localparam int LAT_MEM = 2;
    localparam int LAT_BR  = 1;
    localparam int LAT_CSR = 1;
    localparam int LAT_ALU = 0;
    localparam logic [4:0] R0 = 5'd0;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/issue_scoreboard_sb_entry.sv
// sb_entry: pending-writer count and forward countdown for one architectural register
module sb_entry import issue_scoreboard_pkg::*; #(
    parameter int LAT_W = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,
    input  logic             flush,
    input  logic             acc,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    input  logic [LAT_W-1:0] ld_lat,
    output logic             busy,
    output logic             sat,
    output logic [LAT_W-1:0] fwd
);
    localparam int W = CNT_W + 2;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0] cnt_x, inc_x, dec_x, dec_e, nxt;
    logic ld;

    assign cnt_x = W'(cnt);
    assign inc_x = W'(inc);
    assign dec_x = W'(dec);
    assign dec_e = (dec_x > cnt_x) ? cnt_x : dec_x;
    assign sat   = (cnt_x + inc_x - dec_e) > W'(cnt_max(CNT_W));
    assign ld    = acc && inc != 2'd0;
    assign nxt   = cnt_x + (ld ? inc_x : '0) - dec_e;
    assign busy  = cnt != '0;

    // count nets issue against writeback; fwd loads on issue, otherwise counts down unless frozen
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            fwd <= '0;
        end else if (flush) begin
            cnt <= '0;
            fwd <= '0;
        end else begin
            cnt <= nxt[CNT_W-1:0];
            fwd <= (nxt == '0) ? '0 : ld ? ld_lat : (!stall && fwd != '0) ? fwd - 1'b1 : fwd;
        end
    end
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: tracks in-flight destinations and raises the issue stall for RAW, divide and saturation hazards
module issue_scoreboard import issue_scoreboard_pkg::*; #(
    parameter int NREG  = 32,
    parameter int LAT_W = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,
    input  logic             flush,
    input  logic             eu0_en_in,
    input  logic [4:0]       eu0_rd_in,
    input  logic [4:0]       eu0_rj_in,
    input  logic [4:0]       eu0_rk_in,
    input  logic             eu0_wr_in,
    input  logic [LAT_W-1:0] eu0_lat_in,
    input  logic             eu0_div_in,
    input  logic             eu1_en_in,
    input  logic [4:0]       eu1_rd_in,
    input  logic [4:0]       eu1_rj_in,
    input  logic [4:0]       eu1_rk_in,
    input  logic             eu1_wr_in,
    input  logic [LAT_W-1:0] eu1_lat_in,
    input  logic             write_en_0,
    input  logic [4:0]       write_addr_0,
    input  logic             write_en_1,
    input  logic [4:0]       write_addr_1,
    input  logic             div_done,
    output logic             stall_by_conflict,
    output logic             issue_accept,
    output logic [NREG-1:0]  busy_mask,
    output logic             div_busy
);
    logic [LAT_W-1:0] fwd_a [NREG];
    logic [NREG-1:0] sat_v;
    logic hz0, hz1, pair_hz, div_hz;

    function automatic logic blk(input logic [4:0] s);
        return s != R0 && fwd_a[s] != '0;
    endfunction

    assign fwd_a[0]     = '0;
    assign sat_v[0]     = 1'b0;
    assign busy_mask[0] = 1'b0;

    assign hz0     = eu0_en_in && (blk(eu0_rj_in) || blk(eu0_rk_in));
    assign hz1     = eu1_en_in && (blk(eu1_rj_in) || blk(eu1_rk_in));
    assign pair_hz = eu0_en_in && eu1_en_in && eu0_wr_in && eu0_lat_in != '0 && eu0_rd_in != R0
                     && (eu1_rj_in == eu0_rd_in || eu1_rk_in == eu0_rd_in);
    assign div_hz  = eu0_en_in && eu0_div_in && div_busy;

    assign stall_by_conflict = hz0 || hz1 || pair_hz || div_hz || |sat_v;
    assign issue_accept      = (eu0_en_in || eu1_en_in) && !stall && !flush && !stall_by_conflict;

    for (genvar i = 1; i < NREG; i++) begin : g_ent
        logic h0, h1;
        logic [1:0] inc, dec;
        assign h0  = eu0_en_in && eu0_wr_in && eu0_rd_in == 5'(i);
        assign h1  = eu1_en_in && eu1_wr_in && eu1_rd_in == 5'(i);
        assign inc = {1'b0, h0} + {1'b0, h1};
        assign dec = {1'b0, write_en_0 && write_addr_0 == 5'(i)} + {1'b0, write_en_1 && write_addr_1 == 5'(i)};
        sb_entry #(.LAT_W(LAT_W), .CNT_W(CNT_W)) u_ent (
            .clk    (clk),
            .rstn   (rstn),
            .stall  (stall),
            .flush  (flush),
            .acc    (issue_accept),
            .inc    (inc),
            .dec    (dec),
            .ld_lat (h1 ? eu1_lat_in : eu0_lat_in),
            .busy   (busy_mask[i]),
            .sat    (sat_v[i]),
            .fwd    (fwd_a[i])
        );
    end

    // one divide in flight: a new accept sets the flag and wins over a same-cycle completion
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            div_busy <= 1'b0;
        else if (flush)
            div_busy <= 1'b0;
        else if (issue_accept && eu0_en_in && eu0_div_in)
            div_busy <= 1'b1;
        else if (div_done)
            div_busy <= 1'b0;
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenario checks for issue_scoreboard
module tb_issue_scoreboard;
    logic clk = 1'b0, rstn = 1'b0, stall, flush;
    logic eu0_en_in, eu0_wr_in, eu0_div_in, eu1_en_in, eu1_wr_in;
    logic [4:0] eu0_rd_in, eu0_rj_in, eu0_rk_in, eu1_rd_in, eu1_rj_in, eu1_rk_in;
    logic [2:0] eu0_lat_in, eu1_lat_in;
    logic write_en_0, write_en_1, div_done;
    logic [4:0] write_addr_0, write_addr_1;
    logic stall_by_conflict, issue_accept, div_busy;
    logic [31:0] busy_mask;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    issue_scoreboard #(.NREG(32), .LAT_W(3), .CNT_W(2)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .eu0_en_in(eu0_en_in), .eu0_rd_in(eu0_rd_in), .eu0_rj_in(eu0_rj_in), .eu0_rk_in(eu0_rk_in),
        .eu0_wr_in(eu0_wr_in), .eu0_lat_in(eu0_lat_in), .eu0_div_in(eu0_div_in),
        .eu1_en_in(eu1_en_in), .eu1_rd_in(eu1_rd_in), .eu1_rj_in(eu1_rj_in), .eu1_rk_in(eu1_rk_in),
        .eu1_wr_in(eu1_wr_in), .eu1_lat_in(eu1_lat_in),
        .write_en_0(write_en_0), .write_addr_0(write_addr_0),
        .write_en_1(write_en_1), .write_addr_1(write_addr_1),
        .div_done(div_done), .stall_by_conflict(stall_by_conflict), .issue_accept(issue_accept),
        .busy_mask(busy_mask), .div_busy(div_busy)
    );

    task clr();
        stall = 0; flush = 0; div_done = 0;
        eu0_en_in = 0; eu0_rd_in = 0; eu0_rj_in = 0; eu0_rk_in = 0; eu0_wr_in = 0; eu0_lat_in = 0; eu0_div_in = 0;
        eu1_en_in = 0; eu1_rd_in = 0; eu1_rj_in = 0; eu1_rk_in = 0; eu1_wr_in = 0; eu1_lat_in = 0;
        write_en_0 = 0; write_addr_0 = 0; write_en_1 = 0; write_addr_1 = 0;
    endtask

    task nxt();
        @(negedge clk);
        clr();
    endtask

    task s0(input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk, input logic wr, input logic [2:0] lat, input logic dv);
        eu0_en_in = 1; eu0_rd_in = rd; eu0_rj_in = rj; eu0_rk_in = rk; eu0_wr_in = wr; eu0_lat_in = lat; eu0_div_in = dv;
    endtask

    task s1(input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk, input logic wr, input logic [2:0] lat);
        eu1_en_in = 1; eu1_rd_in = rd; eu1_rj_in = rj; eu1_rk_in = rk; eu1_wr_in = wr; eu1_lat_in = lat;
    endtask

    task test_reset();
        clr();
        #3;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_div: got %b want 0", div_busy); end
        checks++; if (stall_by_conflict !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_by_conflict); end
        checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b want 0", issue_accept); end
        @(negedge clk);
        rstn = 1;
    endtask

    task test_raw();
        nxt(); s0(5, 0, 0, 1, 2, 0); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL raw_prod_accept: got %b want 1", issue_accept); end
        for (int k = 0; k < 2; k++) begin
            nxt(); s0(0, 5, 0, 0, 0, 0); #1;
            checks++; if (stall_by_conflict !== 1'b1) begin errors++; $display("FAIL raw_stall%0d: got %b want 1", k, stall_by_conflict); end
        end
        nxt(); s0(0, 5, 0, 0, 0, 0); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL raw_cons_accept: got %b want 1", issue_accept); end
        nxt(); write_en_0 = 1; write_addr_0 = 5; #1;
        checks++; if (busy_mask[5] !== 1'b1) begin errors++; $display("FAIL raw_busy: got %b want 1", busy_mask[5]); end
        nxt(); #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL raw_release: got %h want 0", busy_mask); end
    endtask

    task test_pair();
        nxt(); s0(7, 0, 0, 1, 3, 0); s1(0, 7, 0, 0, 0); #1;
        checks++; if (stall_by_conflict !== 1'b1) begin errors++; $display("FAIL pair_stall: got %b want 1", stall_by_conflict); end
        nxt(); s0(7, 0, 0, 1, 0, 0); s1(0, 7, 0, 0, 0); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL pair_alu_accept: got %b want 1", issue_accept); end
        nxt(); write_en_0 = 1; write_addr_0 = 7; s0(0, 0, 0, 1, 3, 0); s1(0, 0, 0, 0, 0); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL pair_r0_accept: got %b want 1", issue_accept); end
        nxt(); #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL pair_r0_busy: got %h want 0", busy_mask); end
        nxt(); s0(6, 0, 0, 1, 3, 0); s1(6, 0, 0, 1, 1); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL same_rd_accept: got %b want 1", issue_accept); end
        nxt(); s0(0, 6, 0, 0, 0, 0); #1;
        checks++; if (stall_by_conflict !== 1'b1) begin errors++; $display("FAIL same_rd_stall: got %b want 1", stall_by_conflict); end
        nxt(); s0(0, 6, 0, 0, 0, 0); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL same_rd_eu1_lat: got %b want 1", issue_accept); end
        nxt(); write_en_0 = 1; write_addr_0 = 6; write_en_1 = 1; write_addr_1 = 6; #1;
        checks++; if (busy_mask[6] !== 1'b1) begin errors++; $display("FAIL same_rd_busy: got %b want 1", busy_mask[6]); end
        nxt(); #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL same_rd_dual_wb: got %h want 0", busy_mask); end
    endtask

    task test_div();
        nxt(); s0(0, 0, 0, 0, 0, 1); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL div_first: got %b want 1", issue_accept); end
        nxt(); s0(0, 0, 0, 0, 0, 1); #1;
        checks++; if (stall_by_conflict !== 1'b1) begin errors++; $display("FAIL div_second_stall: got %b want 1", stall_by_conflict); end
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL div_busy_set: got %b want 1", div_busy); end
        nxt(); s0(0, 0, 0, 0, 0, 1); div_done = 1; #1;
        checks++; if (stall_by_conflict !== 1'b1) begin errors++; $display("FAIL div_done_cycle_stall: got %b want 1", stall_by_conflict); end
        nxt(); s0(0, 0, 0, 0, 0, 1); div_done = 1; #1;
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL div_cleared: got %b want 0", div_busy); end
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL div_reissue: got %b want 1", issue_accept); end
        nxt(); div_done = 1; #1;
        checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL div_set_wins: got %b want 1", div_busy); end
        nxt(); #1;
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL div_final_clear: got %b want 0", div_busy); end
    endtask

    task test_freeze();
        nxt(); s0(9, 0, 0, 1, 2, 0); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL frz_prod: got %b want 1", issue_accept); end
        for (int k = 0; k < 4; k++) begin
            nxt(); s0(0, 9, 0, 0, 0, 0); stall = 1; #1;
            checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL frz_hold%0d: got %b want 0", k, issue_accept); end
        end
        for (int k = 0; k < 2; k++) begin
            nxt(); s0(0, 9, 0, 0, 0, 0); #1;
            checks++; if (stall_by_conflict !== 1'b1) begin errors++; $display("FAIL frz_wait%0d: got %b want 1", k, stall_by_conflict); end
        end
        nxt(); s0(0, 9, 0, 0, 0, 0); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL frz_release: got %b want 1", issue_accept); end
        nxt(); write_en_0 = 1; write_addr_0 = 9;
    endtask

    task test_sat();
        for (int k = 0; k < 3; k++) begin
            nxt(); s0(3, 0, 0, 1, 0, 0); #1;
            checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL sat_fill%0d: got %b want 1", k, issue_accept); end
        end
        nxt(); s0(3, 0, 0, 1, 0, 0); #1;
        checks++; if (stall_by_conflict !== 1'b1) begin errors++; $display("FAIL sat_fourth: got %b want 1", stall_by_conflict); end
        nxt(); s0(3, 0, 0, 1, 0, 0); write_en_0 = 1; write_addr_0 = 3; #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL sat_net_accept: got %b want 1", issue_accept); end
        nxt(); s0(3, 0, 0, 1, 0, 0); #1;
        checks++; if (stall_by_conflict !== 1'b1) begin errors++; $display("FAIL sat_net_unchanged: got %b want 1", stall_by_conflict); end
        nxt(); write_en_0 = 1; write_addr_0 = 3; write_en_1 = 1; write_addr_1 = 3;
        nxt(); write_en_0 = 1; write_addr_0 = 3; #1;
        checks++; if (busy_mask[3] !== 1'b1) begin errors++; $display("FAIL sat_drain_busy: got %b want 1", busy_mask[3]); end
        nxt(); #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL sat_drained: got %h want 0", busy_mask); end
    endtask

    task test_flush();
        nxt(); s0(4, 0, 0, 1, 3, 0); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL fl_prod: got %b want 1", issue_accept); end
        nxt(); flush = 1; #1;
        checks++; if (busy_mask[4] !== 1'b1) begin errors++; $display("FAIL fl_pre_busy: got %b want 1", busy_mask[4]); end
        nxt(); s0(0, 4, 0, 0, 0, 0); #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL fl_busy_clear: got %h want 0", busy_mask); end
        checks++; if (stall_by_conflict !== 1'b0) begin errors++; $display("FAIL fl_fwd_clear: got %b want 0", stall_by_conflict); end
        nxt(); write_en_1 = 1; write_addr_1 = 4;
        nxt(); s0(4, 0, 0, 1, 0, 0); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL fl_reissue: got %b want 1", issue_accept); end
        nxt(); #1;
        checks++; if (busy_mask !== 32'h10) begin errors++; $display("FAIL fl_no_underflow: got %h want 00000010", busy_mask); end
        nxt(); s0(4, 0, 0, 1, 2, 0); flush = 1; write_en_0 = 1; write_addr_0 = 4; #1;
        checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL fl_override: got %b want 0", issue_accept); end
        nxt(); #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL fl_override_busy: got %h want 0", busy_mask); end
        nxt(); s0(8, 0, 0, 1, 3, 1); #1;
        checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL ar_prod: got %b want 1", issue_accept); end
        nxt(); #1;
        checks++; if (busy_mask[8] !== 1'b1 || div_busy !== 1'b1) begin errors++; $display("FAIL ar_pre: got busy8=%b div=%b want 1 1", busy_mask[8], div_busy); end
        #1 rstn = 0;
        #1 s0(0, 8, 0, 0, 0, 1);
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL ar_busy: got %h want 0", busy_mask); end
        checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL ar_div: got %b want 0", div_busy); end
        checks++; if (stall_by_conflict !== 1'b0) begin errors++; $display("FAIL ar_stall: got %b want 0", stall_by_conflict); end
        nxt(); rstn = 1;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_pair();
        test_div();
        test_freeze();
        test_sat();
        test_flush();
        nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
